// File: rtl/apply_result_reducer.sv
// rtl/apply_result_reducer.sv - BDD apply return leg: reduce or OR-merge children, unique-table lookup, cache insert, result.
// One request in flight; every output is decoded from the current state and the registered request.
module apply_result_reducer #(
  parameter int IDX_W    = 30,
  parameter int VAR_W    = 16,
  parameter int TYPE_W   = 3,
  parameter int IDX_ZERO = 0,
  parameter int IDX_ONE  = 1,
  parameter int TYPE_OR  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TYPE_W-1:0] req_type,
  input  logic [IDX_W-1:0]  req_f,
  input  logic [IDX_W-1:0]  req_g,
  input  logic [VAR_W-1:0]  req_var,
  input  logic              req_quant,
  input  logic [IDX_W-1:0]  req_low,
  input  logic [IDX_W-1:0]  req_high,
  output logic              ut_valid,
  input  logic              ut_ready,
  output logic [VAR_W-1:0]  ut_var,
  output logic [IDX_W-1:0]  ut_low,
  output logic [IDX_W-1:0]  ut_high,
  input  logic              ut_rsp_valid,
  input  logic [IDX_W-1:0]  ut_rsp_idx,
  output logic              sp_valid,
  input  logic              sp_ready,
  output logic [IDX_W-1:0]  sp_f,
  output logic [IDX_W-1:0]  sp_g,
  output logic [TYPE_W-1:0] sp_type,
  input  logic              sp_rsp_valid,
  input  logic [IDX_W-1:0]  sp_rsp_idx,
  output logic              cw_valid,
  input  logic              cw_ready,
  output logic [TYPE_W-1:0] cw_type,
  output logic [IDX_W-1:0]  cw_f,
  output logic [IDX_W-1:0]  cw_g,
  output logic [IDX_W-1:0]  cw_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_idx
);

  localparam logic [IDX_W-1:0]  IdxZero = IDX_W'(IDX_ZERO);
  localparam logic [IDX_W-1:0]  IdxOne  = IDX_W'(IDX_ONE);
  localparam logic [TYPE_W-1:0] TypeOr  = TYPE_W'(TYPE_OR);

  typedef enum logic [2:0] {
    IDLE, DECIDE, UT_REQ, UT_WAIT, SP_REQ, SP_WAIT, CW, RES
  } state_t;

  state_t state, stateNext;

  logic [TYPE_W-1:0] opType;
  logic [IDX_W-1:0]  opF, opG, opLow, opHigh;
  logic [VAR_W-1:0]  opVar;
  logic              opQuant;
  logic [IDX_W-1:0]  result, resultNext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opType  <= '0;
      opF     <= '0;
      opG     <= '0;
      opVar   <= '0;
      opQuant <= 1'b0;
      opLow   <= '0;
      opHigh  <= '0;
      result  <= '0;
    end else begin
      result <= resultNext;
      if (req_valid && req_ready) begin
        opType  <= req_type;
        opF     <= req_f;
        opG     <= req_g;
        opVar   <= req_var;
        opQuant <= req_quant;
        opLow   <= req_low;
        opHigh  <= req_high;
      end
    end
  end

  always_comb begin
    stateNext  = state;
    resultNext = result;
    req_ready  = 1'b0;
    ut_valid   = 1'b0;
    ut_var     = '0;
    ut_low     = '0;
    ut_high    = '0;
    sp_valid   = 1'b0;
    sp_f       = '0;
    sp_g       = '0;
    sp_type    = '0;
    cw_valid   = 1'b0;
    cw_type    = '0;
    cw_f       = '0;
    cw_g       = '0;
    cw_res     = '0;
    res_valid  = 1'b0;
    res_idx    = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = DECIDE;
      end
      DECIDE: begin
        // Quantified: OR of the children with its terminal identities; otherwise node reduction.
        if (opQuant) begin
          if (opLow == IdxOne || opHigh == IdxOne) begin
            resultNext = IdxOne;
            stateNext  = CW;
          end else if (opLow == IdxZero) begin
            resultNext = opHigh;
            stateNext  = CW;
          end else if (opHigh == IdxZero || opLow == opHigh) begin
            resultNext = opLow;
            stateNext  = CW;
          end else begin
            stateNext = SP_REQ;
          end
        end else if (opLow == opHigh) begin
          resultNext = opLow;
          stateNext  = CW;
        end else begin
          stateNext = UT_REQ;
        end
      end
      UT_REQ: begin
        ut_valid = 1'b1;
        ut_var   = opVar;
        ut_low   = opLow;
        ut_high  = opHigh;
        if (ut_ready) begin
          if (ut_rsp_valid) begin
            resultNext = ut_rsp_idx;
            stateNext  = CW;
          end else begin
            stateNext = UT_WAIT;
          end
        end
      end
      UT_WAIT: begin
        if (ut_rsp_valid) begin
          resultNext = ut_rsp_idx;
          stateNext  = CW;
        end
      end
      SP_REQ: begin
        sp_valid = 1'b1;
        sp_f     = opLow;
        sp_g     = opHigh;
        sp_type  = TypeOr;
        if (sp_ready) begin
          if (sp_rsp_valid) begin
            resultNext = sp_rsp_idx;
            stateNext  = CW;
          end else begin
            stateNext = SP_WAIT;
          end
        end
      end
      SP_WAIT: begin
        if (sp_rsp_valid) begin
          resultNext = sp_rsp_idx;
          stateNext  = CW;
        end
      end
      CW: begin
        cw_valid = 1'b1;
        cw_type  = opType;
        cw_f     = opF;
        cw_g     = opG;
        cw_res   = result;
        if (cw_ready) stateNext = RES;
      end
      RES: begin
        res_valid = 1'b1;
        res_idx   = result;
        if (res_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
